// File: rtl/uart_ahb_sequencer_pkg.sv
// Shared AHB-Lite encodings and state/completion-code types for the UART AHB sequencer.
package uart_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_SLAVE   = 2'b01,
    ERR_RETRY   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_e;

endpackage

// File: rtl/uart_ahb_sequencer_rr_arbiter.sv
// Round-robin requester pick. Searches upward from the owned pointer, wrapping;
// the pointer moves past the served requester when advance is strobed.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic [IDX_W-1:0] adv_idx,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (adv_idx == IDX_W'(N_REQ - 1)) ? '0 : adv_idx + IDX_W'(1);
    end
  end

  always_comb begin : pick
    int j;
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_ahb_sequencer.sv
// AHB-Lite single-byte master serving N_REQ requesters toward the AHB-to-APB UART
// subsystem: round-robin grant, address/data phases, retry, error and stall timeout.
module uart_ahb_sequencer
  import uart_ahb_pkg::*;
#(
  parameter int          N_REQ     = 2,
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 16,
  parameter int          MAX_RETRY = 3
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        we_i,
  input  logic [N_REQ*ADDR_W-1:0] addr_i,
  input  logic [N_REQ*8-1:0]      wdata_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        done_o,
  output logic [7:0]              rdata_o,
  output logic [1:0]              err_code_o,
  output logic                    busy_o,
  output logic                    HSELABPif,
  output logic [1:0]              HTRANS,
  output logic                    HWRITE,
  output logic [2:0]              HSIZES,
  output logic [2:0]              HBURST,
  output logic [31:0]             HADDR,
  output logic [31:0]             HWDATA,
  output logic                    HREADYin,
  input  logic                    HREADY,
  input  logic [1:0]              HRESP,
  input  logic [31:0]             HRDATA
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e            state, state_n;
  logic              arb_any;
  logic [IDX_W-1:0]  arb_idx;
  logic              grant, advance, finish, load_rdata, retry_inc, stall_hit;
  err_code_e         fin_code, err_q;
  logic [IDX_W-1:0]  idx_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q, rdata_q;
  logic [RTY_W-1:0]  retry_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic              unused_hrdata;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .req     (req_i),
    .advance (advance),
    .adv_idx (idx_q),
    .any     (arb_any),
    .idx     (arb_idx)
  );

  assign HSIZES        = HSIZE_BYTE;
  assign HBURST        = HBURST_SINGLE;
  assign HREADYin      = HREADY;
  assign busy_o        = (state != IDLE);
  assign rdata_o       = rdata_q;
  assign err_code_o    = err_q;
  assign stall_hit     = !HREADY && (stall_cnt == CNT_W'(TIMEOUT - 1));
  assign unused_hrdata = ^HRDATA[31:8];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    gnt_o      = '0;
    done_o     = '0;
    HSELABPif  = 1'b0;
    HTRANS     = HTRANS_IDLE;
    HWRITE     = 1'b0;
    HADDR      = '0;
    HWDATA     = '0;
    grant      = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    load_rdata = 1'b0;
    retry_inc  = 1'b0;
    fin_code   = ERR_OK;
    case (state)
      IDLE: begin
        // Grant is suppressed while reset is held so gnt_o reads as its reset value.
        if (arb_any && HRESETn) begin
          gnt_o[arb_idx] = 1'b1;
          grant          = 1'b1;
          state_n        = ADDR;
        end
      end
      ADDR: begin
        HSELABPif = 1'b1;
        HTRANS    = HTRANS_NONSEQ;
        HWRITE    = we_q;
        HADDR     = BASE_ADDR | 32'(addr_q);
        if (HREADY) begin
          state_n = DATA;
        end else if (stall_hit) begin
          finish   = 1'b1;
          fin_code = ERR_TIMEOUT;
        end
      end
      DATA: begin
        HWDATA = {24'h0, wdata_q};
        if (HREADY) begin
          case (HRESP)
            HRESP_OKAY: begin
              finish     = 1'b1;
              load_rdata = !we_q;
            end
            HRESP_ERROR: begin
              finish   = 1'b1;
              fin_code = ERR_SLAVE;
            end
            HRESP_RETRY, HRESP_SPLIT: begin
              if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                retry_inc = 1'b1;
                state_n   = ADDR;
              end else begin
                finish   = 1'b1;
                fin_code = ERR_RETRY;
              end
            end
            default: ;
          endcase
        end else if (stall_hit) begin
          finish   = 1'b1;
          fin_code = ERR_TIMEOUT;
        end
      end
      DONE: begin
        done_o[idx_q] = 1'b1;
        advance       = 1'b1;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (finish) state_n = DONE;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      retry_cnt <= '0;
      stall_cnt <= '0;
      rdata_q   <= '0;
      err_q     <= ERR_OK;
    end else begin
      // Stall count restarts on every phase entry, including a retry back to ADDR.
      if (state_n != state)
        stall_cnt <= '0;
      else if (!HREADY && (state == ADDR || state == DATA))
        stall_cnt <= stall_cnt + CNT_W'(1);

      if (state == DONE)
        retry_cnt <= '0;
      else if (retry_inc)
        retry_cnt <= retry_cnt + RTY_W'(1);

      if (finish) begin
        err_q <= fin_code;
        if (load_rdata) rdata_q <= HRDATA[7:0];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (grant) begin
      idx_q   <= arb_idx;
      we_q    <= we_i[arb_idx];
      addr_q  <= addr_i[arb_idx*ADDR_W +: ADDR_W];
      wdata_q <= wdata_i[arb_idx*8 +: 8];
    end
  end

endmodule

// File: tb/tb_uart_ahb_sequencer.sv
// Directed bench for uart_ahb_sequencer: grant/phase timing, waits, contention,
// retry, timeout and reset mid-transfer against hand-computed values.
module tb_uart_ahb_sequencer;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 12;

  logic                    HCLK = 1'b0;
  logic                    HRESETn;
  logic [N_REQ-1:0]        req_i, we_i;
  logic [N_REQ*ADDR_W-1:0] addr_i;
  logic [N_REQ*8-1:0]      wdata_i;
  logic [N_REQ-1:0]        gnt_o, done_o;
  logic [7:0]              rdata_o;
  logic [1:0]              err_code_o;
  logic                    busy_o, HSELABPif, HWRITE, HREADYin, HREADY;
  logic [1:0]              HTRANS, HRESP;
  logic [2:0]              HSIZES, HBURST;
  logic [31:0]             HADDR, HWDATA, HRDATA;

  int n_cmp = 0;
  int n_bad = 0;

  uart_ahb_sequencer dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .done_o     (done_o),
    .rdata_o    (rdata_o),
    .err_code_o (err_code_o),
    .busy_o     (busy_o),
    .HSELABPif  (HSELABPif),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZES     (HSIZES),
    .HBURST     (HBURST),
    .HADDR      (HADDR),
    .HWDATA     (HWDATA),
    .HREADYin   (HREADYin),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA)
  );

  always #5 HCLK = ~HCLK;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic test_reset();
    HRESETn = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
    repeat (3) @(negedge HCLK);
    #1;
    n_cmp++;
    if ({gnt_o, done_o, rdata_o, err_code_o, busy_o, HSELABPif, HTRANS, HWRITE,
         HADDR, HWDATA, HSIZES, HBURST} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got gnt=%b done=%b rdata=%h err=%b busy=%b hsel=%b htrans=%b hwrite=%b haddr=%h hwdata=%h hsize=%b hburst=%b, want all zero",
               gnt_o, done_o, rdata_o, err_code_o, busy_o, HSELABPif, HTRANS, HWRITE, HADDR, HWDATA, HSIZES, HBURST);
    end
    n_cmp++;
    if (HREADYin !== 1'b1) begin
      n_bad++; $display("FAIL reset_hreadyin: got %b want 1", HREADYin);
    end
    HRESETn = 1'b1;
  endtask

  task automatic test_contention();
    logic [1:0]  exp;
    logic [31:0] exp_addr;
    @(negedge HCLK);
    req_i = 2'b11; we_i = 2'b11; addr_i = {12'h020, 12'h010}; wdata_i = {8'h22, 8'h11};
    for (int t = 0; t < 4; t++) begin
      exp      = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (t % 2 == 0) ? 32'h10 : 32'h20;
      if (t > 0) @(negedge HCLK);
      #1;
      n_cmp++;
      if (gnt_o !== exp) begin
        n_bad++; $display("FAIL cont_gnt[%0d]: got %b want %b", t, gnt_o, exp);
      end
      @(negedge HCLK); #1;
      n_cmp++;
      if (HADDR !== exp_addr) begin
        n_bad++; $display("FAIL cont_haddr[%0d]: got %h want %h", t, HADDR, exp_addr);
      end
      @(negedge HCLK); @(negedge HCLK); #1;
      n_cmp++;
      if ({done_o, gnt_o} !== {exp, 2'b00}) begin
        n_bad++; $display("FAIL cont_done[%0d]: got done=%b gnt=%b want done=%b gnt=00", t, done_o, gnt_o, exp);
      end
    end
    @(negedge HCLK);
    req_i = '0;
  endtask

  task automatic test_write();
    @(negedge HCLK);
    req_i = 2'b01; we_i = 2'b01; addr_i = {12'h000, 12'h004}; wdata_i = {8'h00, 8'hA5};
    #1;
    n_cmp++;
    if (gnt_o !== 2'b01) begin
      n_bad++; $display("FAIL wr_gnt: got %b want 01", gnt_o);
    end
    @(negedge HCLK); req_i = '0; #1;
    n_cmp++;
    if ({HSELABPif, HTRANS, HWRITE, HADDR} !== {1'b1, 2'b10, 1'b1, 32'h4}) begin
      n_bad++; $display("FAIL wr_addr_phase: got hsel=%b htrans=%b hwrite=%b haddr=%h want 1 10 1 00000004",
                        HSELABPif, HTRANS, HWRITE, HADDR);
    end
    @(negedge HCLK); #1;
    n_cmp++;
    if ({HSELABPif, HTRANS, HWDATA} !== {1'b0, 2'b00, 32'hA5}) begin
      n_bad++; $display("FAIL wr_data_phase: got hsel=%b htrans=%b hwdata=%h want 0 00 000000a5",
                        HSELABPif, HTRANS, HWDATA);
    end
    @(negedge HCLK); #1;
    n_cmp++;
    if ({done_o, err_code_o} !== {2'b01, 2'b00}) begin
      n_bad++; $display("FAIL wr_done: got done=%b err=%b want 01 00", done_o, err_code_o);
    end
    @(negedge HCLK); #1;
    n_cmp++;
    if ({busy_o, done_o} !== 3'b000) begin
      n_bad++; $display("FAIL wr_idle: got busy=%b done=%b want 0 00", busy_o, done_o);
    end
  endtask

  task automatic test_read_wait();
    @(negedge HCLK);
    req_i = 2'b01; we_i = 2'b00; addr_i = {12'h000, 12'h010}; wdata_i = '0;
    @(negedge HCLK); req_i = '0; #1;
    n_cmp++;
    if ({HTRANS, HWRITE, HADDR} !== {2'b10, 1'b0, 32'h10}) begin
      n_bad++; $display("FAIL rd_addr_phase: got htrans=%b hwrite=%b haddr=%h want 10 0 00000010", HTRANS, HWRITE, HADDR);
    end
    for (int w = 0; w < 2; w++) begin
      @(negedge HCLK); HREADY = 1'b0; #1;
      n_cmp++;
      if ({HTRANS, HWDATA, busy_o, done_o, HREADYin} !== {2'b00, 32'h0, 1'b1, 2'b00, 1'b0}) begin
        n_bad++; $display("FAIL rd_wait[%0d]: got htrans=%b hwdata=%h busy=%b done=%b hreadyin=%b want 00 0 1 00 0",
                          w, HTRANS, HWDATA, busy_o, done_o, HREADYin);
      end
    end
    @(negedge HCLK); HREADY = 1'b1; HRDATA = 32'h0000_003C;
    @(negedge HCLK); HRDATA = '0; #1;
    n_cmp++;
    if ({done_o, rdata_o, err_code_o} !== {2'b01, 8'h3C, 2'b00}) begin
      n_bad++; $display("FAIL rd_done: got done=%b rdata=%h err=%b want 01 3c 00", done_o, rdata_o, err_code_o);
    end
  endtask

  task automatic test_retry();
    int         naddr, dcyc;
    logic [1:0] derr, dgnt;
    naddr = 0; dcyc = -1; derr = 2'b00; dgnt = 2'b00;
    @(negedge HCLK);
    req_i = 2'b01; we_i = 2'b01; addr_i = {12'h000, 12'h008}; wdata_i = {8'h00, 8'h77};
    HRESP = 2'b10;
    for (int c = 0; c < 40 && dcyc < 0; c++) begin
      if (c > 0) @(negedge HCLK);
      if (c == 1) req_i = '0;
      #1;
      if (HTRANS == 2'b10) naddr++;
      if (done_o != '0) begin dcyc = c; derr = err_code_o; dgnt = done_o; end
    end
    HRESP = 2'b00;
    n_cmp++;
    if (naddr != 4) begin
      n_bad++; $display("FAIL retry_addr_phases: got %0d want 4", naddr);
    end
    n_cmp++;
    if ({dcyc, dgnt, derr} !== {32'sd9, 2'b01, 2'b10}) begin
      n_bad++; $display("FAIL retry_exhausted: got cycle=%0d done=%b err=%b want 9 01 10", dcyc, dgnt, derr);
    end

    // One RETRY then OKAY, read from requester 1.
    @(negedge HCLK);
    req_i = 2'b10; we_i = 2'b00; addr_i = {12'h00C, 12'h000};
    #1;
    n_cmp++;
    if (gnt_o !== 2'b10) begin
      n_bad++; $display("FAIL retry1_gnt: got %b want 10", gnt_o);
    end
    @(negedge HCLK); req_i = '0;
    @(negedge HCLK); HRESP = 2'b10;
    @(negedge HCLK); HRESP = 2'b00; #1;
    n_cmp++;
    if ({HTRANS, HADDR} !== {2'b10, 32'hC}) begin
      n_bad++; $display("FAIL retry1_reissue: got htrans=%b haddr=%h want 10 0000000c", HTRANS, HADDR);
    end
    @(negedge HCLK); HRDATA = 32'h0000_005A;
    @(negedge HCLK); HRDATA = '0; #1;
    n_cmp++;
    if ({done_o, err_code_o, rdata_o} !== {2'b10, 2'b00, 8'h5A}) begin
      n_bad++; $display("FAIL retry1_done: got done=%b err=%b rdata=%h want 10 00 5a", done_o, err_code_o, rdata_o);
    end
  endtask

  task automatic test_timeout();
    int         nstall, dcyc;
    logic [1:0] derr, dtrans;
    nstall = 0; dcyc = -1; derr = 2'b00; dtrans = 2'b11;
    @(negedge HCLK);
    req_i = 2'b01; we_i = 2'b01; addr_i = {12'h000, 12'h018}; wdata_i = {8'h00, 8'h33};
    // Sixteen stalled address-phase cycles (1..16), then the completion pulse.
    for (int c = 1; c < 60 && dcyc < 0; c++) begin
      @(negedge HCLK);
      if (c == 1) begin req_i = '0; HREADY = 1'b0; end
      #1;
      if (done_o != '0) begin
        dcyc = c; derr = err_code_o; dtrans = HTRANS;
      end else if (HTRANS == 2'b10 && HADDR == 32'h18) begin
        nstall++;
      end
    end
    n_cmp++;
    if ({nstall, dcyc} !== {32'sd16, 32'sd17}) begin
      n_bad++; $display("FAIL timeout_timing: got stalls=%0d done_cycle=%0d want 16 17", nstall, dcyc);
    end
    n_cmp++;
    if ({derr, dtrans} !== {2'b11, 2'b00}) begin
      n_bad++; $display("FAIL timeout_code: got err=%b htrans=%b want 11 00", derr, dtrans);
    end
    @(negedge HCLK); #1;
    n_cmp++;
    if ({busy_o, HTRANS, HSELABPif} !== 4'b0000) begin
      n_bad++; $display("FAIL timeout_idle: got busy=%b htrans=%b hsel=%b want 0 00 0", busy_o, HTRANS, HSELABPif);
    end
    HREADY = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge HCLK);
    req_i = 2'b01; we_i = 2'b01; addr_i = {12'h000, 12'h01C}; wdata_i = {8'h00, 8'h44};
    @(negedge HCLK); req_i = '0;
    @(negedge HCLK); HREADY = 1'b0; #1;
    n_cmp++;
    if ({HTRANS, HWDATA, busy_o} !== {2'b00, 32'h44, 1'b1}) begin
      n_bad++; $display("FAIL mid_in_data: got htrans=%b hwdata=%h busy=%b want 00 00000044 1", HTRANS, HWDATA, busy_o);
    end
    HRESETn = 1'b0;
    @(negedge HCLK); #1;
    n_cmp++;
    if ({gnt_o, done_o, rdata_o, err_code_o, busy_o, HSELABPif, HTRANS, HWRITE, HADDR, HWDATA} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got gnt=%b done=%b rdata=%h err=%b busy=%b hsel=%b htrans=%b hwrite=%b haddr=%h hwdata=%h, want all zero",
               gnt_o, done_o, rdata_o, err_code_o, busy_o, HSELABPif, HTRANS, HWRITE, HADDR, HWDATA);
    end
    HRESETn = 1'b1; HREADY = 1'b1;
    req_i = 2'b11; we_i = 2'b00; addr_i = {12'h02C, 12'h028};
    #1;
    n_cmp++;
    if (gnt_o !== 2'b01) begin
      n_bad++; $display("FAIL mid_regrant: got %b want 01", gnt_o);
    end
    @(negedge HCLK); req_i = '0; #1;
    n_cmp++;
    if ({HADDR, done_o} !== {32'h28, 2'b00}) begin
      n_bad++; $display("FAIL mid_new_addr: got haddr=%h done=%b want 00000028 00", HADDR, done_o);
    end
    @(negedge HCLK); @(negedge HCLK); #1;
    n_cmp++;
    if ({done_o, err_code_o} !== {2'b01, 2'b00}) begin
      n_bad++; $display("FAIL mid_new_done: got done=%b err=%b want 01 00", done_o, err_code_o);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_write();
    test_read_wait();
    test_retry();
    test_timeout();
    test_reset_mid();
    @(negedge HCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100us want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_ahb_sequencer.md
Name: uart_ahb_sequencer

Overview:
- AHB-Lite single-transfer master that drives the AHB-to-APB UART subsystem on behalf of N_REQ on-chip requesters (for example, a CPU command port and a debug/loader port).
- Arbitrates requesters round-robin.
- Sequences each byte access through the AHB address and data phases.
- Handles wait states, RETRY/SPLIT re-issue, ERROR responses and stall timeout.
- Returns read data and a completion code to the granted requester.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- ADDR_W, 12, requester register-offset width (UART APB offset space).
- BASE_ADDR, 32'h0000_0000, OR-ed onto the offset to form HADDR.
- TIMEOUT, 16, maximum consecutive HREADY=0 cycles per phase before abort.
- MAX_RETRY, 3, re-issues allowed on RETRY/SPLIT before failing.

Ports:
- HCLK  in  1  system clock, rising edge.
- HRESETn  in  1  synchronous active-low reset.
- req_i  in  N_REQ  per-requester access request, level.
- we_i  in  N_REQ  1=write, 0=read.
- addr_i  in  N_REQ*ADDR_W  packed offsets, requester k at [k*ADDR_W +: ADDR_W].
- wdata_i  in  N_REQ*8  packed write bytes.
- gnt_o  out  N_REQ  one-cycle pulse; the command is captured this cycle.
- done_o  out  N_REQ  one-cycle completion pulse.
- rdata_o  out  8  read byte, valid with done_o.
- err_code_o  out  2  valid with done_o: 00 OK, 01 slave ERROR, 10 retry exhausted, 11 timeout.
- busy_o  out  1  high whenever state is not IDLE.
- HSELABPif  out  1  slave select.
- HTRANS  out  2  transfer type.
- HWRITE  out  1  write strobe.
- HSIZES  out  3  transfer size.
- HBURST  out  3  burst type.
- HADDR  out  32  address.
- HWDATA  out  32  write data.
- HREADYin  out  1  bus HREADY looped back to the slave; equals HREADY combinationally.
- HREADY  in  1  slave HREADYout.
- HRESP  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- HRDATA  in  32  read data.

Behaviour:
- Reset (synchronous; HRESETn sampled low at a rising edge):
  - State goes to IDLE; rr_ptr=0; retry and timeout counters cleared.
  - Outputs: gnt_o=0, done_o=0, rdata_o=0, err_code_o=0, busy_o=0, HSELABPif=0, HTRANS=2'b00, HWRITE=0, HADDR=0, HWDATA=0.
  - HSIZES=3'b000 and HBURST=3'b000 at all times.
  - Reset mid-transfer abandons the transfer silently: no done_o pulse.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If any req_i bit is set, pick the first set bit searching upward from rr_ptr, wrapping.
  - Pulse gnt_o[k]; latch we, addr and wdata plus the grant index; go to ADDR.
  - The requester may deassert req_i after gnt_o.
- ADDR:
  - Drive HSELABPif=1, HTRANS=2'b10 (NONSEQ), HWRITE=we, HADDR=BASE_ADDR | addr.
  - Hold all address-phase signals stable while HREADY=0.
  - HREADY=1 moves to DATA.
- DATA:
  - Drive HSELABPif=0, HTRANS=2'b00, HWDATA={24'h0, wdata} held stable.
  - Wait for HREADY=1, then evaluate HRESP:
    - OKAY: capture HRDATA[7:0] into rdata_o on reads, code 00, go to DONE.
    - ERROR: code 01, go to DONE; rdata_o unchanged.
    - RETRY/SPLIT: if retry_cnt < MAX_RETRY, increment retry_cnt and return to ADDR; else code 10, go to DONE.
- Timeout:
  - The stall counter clears on each entry to ADDR or DATA and counts cycles with HREADY=0.
  - When it reaches TIMEOUT, set code 11, drive HTRANS=00 and HSELABPif=0, go to DONE.
- DONE:
  - Pulse done_o[k] with rdata_o and err_code_o stable.
  - Set rr_ptr=(k+1) mod N_REQ; clear retry_cnt; go to IDLE.
  - No grant is issued in DONE.
- Latency:
  - Zero-wait slave: req sampled in cycle 0 (gnt), ADDR in cycle 1, DATA in cycle 2, done_o in cycle 3.
  - Back-to-back commands: the next gnt can occur in the cycle after DONE, so throughput is one transfer per 4 cycles.
- Simultaneous requests: round-robin gives strict alternation under continuous contention; no requester waits more than N_REQ-1 transfers.
- rdata_o and err_code_o hold their values until the next DONE.

Decomposition:
- Package uart_ahb_pkg holds:
  - HTRANS_IDLE/NONSEQ, HRESP_OKAY/ERROR/RETRY/SPLIT, HSIZE_BYTE, HBURST_SINGLE constants.
  - state_e enum {IDLE, ADDR, DATA, DONE}.
  - err_code_e enum.
- One sub-module, rr_arbiter: N_REQ-wide round-robin priority pick from rr_ptr. It is combinational apart from the pointer register, which it owns and updates on an advance strobe.

Test Plan:
- Single write, zero-wait: req_i=01, we=1, addr=12'h004, wdata=8'hA5 -> gnt_o=01 at cycle 0; HADDR=32'h4 with HTRANS=10 at cycle 1; HWDATA=32'hA5 at cycle 2; done_o=01 with err=00 at cycle 3.
- Read with 2 wait states in DATA, HRDATA=32'h0000_003C -> done at cycle 5, rdata_o=8'h3C, err=00; HWDATA and HTRANS stable during waits.
- Contention: req_i=11 held for 4 transfers -> grants in order 01, 10, 01, 10; each done_o matches the preceding gnt_o.
- HRESP=RETRY on every attempt, MAX_RETRY=3 -> 4 NONSEQ address phases observed, then done with err=10. A single RETRY followed by OKAY -> err=00.
- HREADY stuck at 0 in ADDR, TIMEOUT=16 -> done at the 16th stall cycle with err=11; HTRANS=00 afterwards; busy_o=0 the cycle after done.
- HRESETn=0 asserted during DATA -> next edge: state IDLE, done_o never pulses, all outputs at reset values; a new req is granted after release with rr_ptr=0.
